// File: rtl/i2s_dac_tx.sv
// I2S transmitter: one-sample holding buffer, BCLK/LRCLK generation, 24-bit MSB-first slots in 32-bit halves.
// Optional I2S_TX_STEREO_EN adds a separate right-channel input; otherwise the left sample is sent on both channels.
module i2s_dac_tx #(
  parameter int BCLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] sample_in,
  input  logic        sample_valid,
`ifdef I2S_TX_STEREO_EN
  input  logic [31:0] sample_in_r,
`endif
  output logic        sample_ready,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata,
  output logic        sample_tick,
  output logic        underrun
);

  localparam int DIVW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(BCLK_DIV - 1);

  logic [DIVW-1:0] r_div_cnt;
  logic            r_bclk;
  logic [5:0]      r_bit_cnt;
  logic            r_lrclk;
  logic            r_sdata;
  logic            r_full;
  logic [23:0]     r_hold_l;
  logic [23:0]     r_frame_l;
  logic            r_tick;
  logic            r_underrun;

  logic            w_div_end;
  logic            w_fall;
  logic            w_load;
  logic            w_accept;
  logic [5:0]      w_bit_nxt;
  logic            w_slot_bit;
  logic [23:0]     w_in_r;
  logic [23:0]     w_frame_r;
  logic            w_unused_hi;

`ifdef I2S_TX_STEREO_EN
  logic [23:0]     r_hold_r;
  logic [23:0]     r_frame_r;

  assign w_in_r      = sample_in_r[23:0];
  assign w_frame_r   = r_frame_r;
  assign w_unused_hi = ^{sample_in[31:24], sample_in_r[31:24]};
`else
  assign w_in_r      = sample_in[23:0];
  assign w_frame_r   = r_frame_l;
  assign w_unused_hi = ^sample_in[31:24];
`endif

  assign w_div_end  = (r_div_cnt == DIV_LAST);
  assign w_fall     = w_div_end & r_bclk;
  assign w_bit_nxt  = r_bit_cnt + 6'd1;
  assign w_load     = w_fall & (r_bit_cnt == 6'd63);
  assign w_accept   = sample_valid & ~r_full;

  assign sample_ready = ~r_full;
  assign bclk         = r_bclk;
  assign lrclk        = r_lrclk;
  assign sdata        = r_sdata;
  assign sample_tick  = r_tick;
  assign underrun     = r_underrun;

  // Slots 0 and 32 stay zero, giving the one-bit delay after each lrclk edge.
  always_comb begin
    w_slot_bit = 1'b0;
    if ((w_bit_nxt >= 6'd1) && (w_bit_nxt <= 6'd24)) begin
      w_slot_bit = r_frame_l[5'(6'd24 - w_bit_nxt)];
    end else if ((w_bit_nxt >= 6'd33) && (w_bit_nxt <= 6'd56)) begin
      w_slot_bit = w_frame_r[5'(6'd56 - w_bit_nxt)];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
      r_bit_cnt <= '1;
      r_lrclk   <= 1'b1;
      r_sdata   <= 1'b0;
    end else begin
      r_div_cnt <= w_div_end ? '0 : r_div_cnt + 1'b1;
      if (w_div_end) begin
        r_bclk <= ~r_bclk;
      end
      if (w_fall) begin
        r_bit_cnt <= w_bit_nxt;
        r_lrclk   <= w_bit_nxt[5];
        r_sdata   <= w_slot_bit;
      end
    end
  end

  // An accept coinciding with a load on an empty buffer goes straight into the frame register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full     <= 1'b0;
      r_hold_l   <= '0;
      r_frame_l  <= '0;
      r_tick     <= 1'b0;
      r_underrun <= 1'b0;
`ifdef I2S_TX_STEREO_EN
      r_hold_r   <= '0;
      r_frame_r  <= '0;
`endif
    end else begin
      r_tick     <= w_load;
      r_underrun <= w_load & ~r_full & ~w_accept;
      if (w_load) begin
        if (r_full) begin
          r_frame_l <= r_hold_l;
`ifdef I2S_TX_STEREO_EN
          r_frame_r <= r_hold_r;
`endif
          r_full    <= 1'b0;
        end else if (w_accept) begin
          r_frame_l <= sample_in[23:0];
`ifdef I2S_TX_STEREO_EN
          r_frame_r <= w_in_r;
`endif
        end
      end else if (w_accept) begin
        r_hold_l <= sample_in[23:0];
`ifdef I2S_TX_STEREO_EN
        r_hold_r <= w_in_r;
`endif
        r_full   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Self-checking bench for i2s_dac_tx: frame-level reference model predicts every output on every clk cycle.
module tb_i2s_dac_tx;
  localparam int unsigned D = 4;
  localparam int unsigned FRAME = 128 * D;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] sample_in = '0;
  logic        sample_valid = 1'b0;
`ifdef I2S_TX_STEREO_EN
  logic [31:0] sample_in_r = '0;
`endif
  logic sample_ready, bclk, lrclk, sdata, sample_tick, underrun;
  logic [5:0] obs;

  int n_cmp = 0;
  int n_bad = 0;

  int unsigned m_n;
  logic        m_full, m_tick, m_unr, m_acc;
  logic [23:0] m_hold_l, m_hold_r, m_frame_l, m_frame_r;
  logic [5:0]  exp_vec;

  i2s_dac_tx #(.BCLK_DIV(D)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
`ifdef I2S_TX_STEREO_EN
    .sample_in_r(sample_in_r),
`endif
    .sample_ready(sample_ready), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
    .sample_tick(sample_tick), .underrun(underrun)
  );

  assign obs = {bclk, lrclk, sdata, sample_ready, sample_tick, underrun};

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic slot_bit(int unsigned k);
    if (k >= 1 && k <= 24) return m_frame_l[24 - k];
    if (k >= 33 && k <= 56) return m_frame_r[56 - k];
    return 1'b0;
  endfunction

  // Expected outputs after clk edge m_n counted from reset release.
  function automatic logic [5:0] expect_out();
    int unsigned falls, k;
    logic b;
    falls = m_n / (2 * D);
    k     = (63 + falls) % 64;
    b     = ((m_n / D) % 2) == 1;
    return {b, logic'(k >= 32), slot_bit(k), ~m_full, m_tick, m_unr};
  endfunction

  function automatic bit is_load(int unsigned n);
    return (n >= 2 * D) && (((n - 2 * D) % FRAME) == 0);
  endfunction

  task automatic model_init();
    m_n = 0; m_full = 0; m_tick = 0; m_unr = 0; m_acc = 0;
    m_hold_l = '0; m_hold_r = '0; m_frame_l = '0; m_frame_r = '0;
    exp_vec = expect_out();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    sample_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_init();
  endtask

  task automatic tick(input logic v, input logic [31:0] d, input logic [31:0] dr);
    logic [23:0] r;
    bit load;
    sample_valid = v;
    sample_in    = d;
`ifdef I2S_TX_STEREO_EN
    sample_in_r  = dr;
    r = dr[23:0];
`else
    r = d[23:0];
`endif
    m_n++;
    load   = is_load(m_n);
    m_acc  = v && !m_full;
    m_tick = load;
    m_unr  = 1'b0;
    if (load) begin
      if (m_full) begin
        m_frame_l = m_hold_l; m_frame_r = m_hold_r; m_full = 1'b0;
      end else if (m_acc) begin
        m_frame_l = d[23:0]; m_frame_r = r;
      end else begin
        m_unr = 1'b1;
      end
    end else if (m_acc) begin
      m_hold_l = d[23:0]; m_hold_r = r; m_full = 1'b1;
    end
    @(negedge clk);
    exp_vec = expect_out();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 300; i++) begin
      tick(($urandom_range(0, 99) == 0), $urandom, $urandom);
      n_cmp++;
      if (obs !== exp_vec) begin n_bad++; $display("FAIL reset_pre n=%0d got=%b exp=%b", m_n, obs, exp_vec); end
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 6'b010100) begin n_bad++; $display("FAIL reset_async got=%b exp=%b", obs, 6'b010100); end
    @(posedge clk); #1;
    n_cmp++;
    if (obs !== 6'b010100) begin n_bad++; $display("FAIL reset_hold got=%b exp=%b", obs, 6'b010100); end
    @(negedge clk);
    reset = 1'b1;
    model_init();
    for (int i = 1; i <= 10; i++) begin
      tick(1'b0, '0, '0);
      n_cmp++;
      if (obs !== exp_vec) begin n_bad++; $display("FAIL reset_seq n=%0d got=%b exp=%b", m_n, obs, exp_vec); end
      if (i == 3 || i == 4) begin
        n_cmp++;
        if (bclk !== (i == 4)) begin n_bad++; $display("FAIL first_bclk_rise edge=%0d got=%b exp=%b", i, bclk, (i == 4)); end
      end
      if (i == 8) begin
        n_cmp++;
        if ({lrclk, sample_tick, underrun} !== 3'b011) begin
          n_bad++; $display("FAIL first_load got=%b exp=011", {lrclk, sample_tick, underrun});
        end
      end
    end
  endtask

  task automatic test_pattern();
    logic v;
    logic [31:0] d;
    apply_reset();
    for (int i = 0; i < 1600; i++) begin
      v = (i == 0) || (i == 600);
      d = (i == 0) ? 32'h00A5A5A5 : 32'hFF800000;
      tick(v, d, d);
      n_cmp++;
      if (obs !== exp_vec) begin n_bad++; $display("FAIL pattern n=%0d got=%b exp=%b", m_n, obs, exp_vec); end
      if (m_n == 16 || m_n == 24 || m_n == 208) begin
        n_cmp++;
        if (sdata !== (m_n == 16)) begin n_bad++; $display("FAIL pattern_bit n=%0d got=%b exp=%b", m_n, sdata, (m_n == 16)); end
      end
    end
  endtask

  task automatic test_backpressure();
    int phase;
    logic [31:0] a, b;
    phase = 0;
    a = $urandom; b = $urandom;
    for (int i = 0; i < 1700; i++) begin
      tick(phase < 2, (phase == 0) ? a : b, (phase == 0) ? ~a : ~b);
      if (m_acc && phase < 2) phase++;
      n_cmp++;
      if (obs !== exp_vec) begin n_bad++; $display("FAIL backpressure n=%0d got=%b exp=%b", m_n, obs, exp_vec); end
    end
    n_cmp++;
    if (phase !== 2) begin n_bad++; $display("FAIL backpressure_accepts got=%0d exp=2", phase); end
  endtask

  task automatic test_underrun();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 1100; i++) begin
      tick(1'b0, $urandom, $urandom);
      if (m_unr) pulses++;
      n_cmp++;
      if (obs !== exp_vec) begin n_bad++; $display("FAIL underrun n=%0d got=%b exp=%b", m_n, obs, exp_vec); end
    end
    n_cmp++;
    if (pulses < 2) begin n_bad++; $display("FAIL underrun_count got=%0d exp>=2", pulses); end
  endtask

  task automatic test_bypass();
    int budget;
    budget = 0;
    while (!(is_load(m_n + 1) && !m_full) && budget < 2000) begin
      tick(1'b0, '0, '0);
      budget++;
      n_cmp++;
      if (obs !== exp_vec) begin n_bad++; $display("FAIL bypass_wait n=%0d got=%b exp=%b", m_n, obs, exp_vec); end
    end
    n_cmp++;
    if (budget >= 2000) begin n_bad++; $display("FAIL bypass_timeout got=%0d exp<2000", budget); end
    tick(1'b1, 32'h00123456, 32'h00123456);
    n_cmp++;
    if ({sample_tick, underrun, sample_ready} !== 3'b101) begin
      n_bad++; $display("FAIL bypass_load got=%b exp=101", {sample_tick, underrun, sample_ready});
    end
    for (int i = 0; i < 600; i++) begin
      tick(1'b0, '0, '0);
      n_cmp++;
      if (obs !== exp_vec) begin n_bad++; $display("FAIL bypass n=%0d got=%b exp=%b", m_n, obs, exp_vec); end
    end
  endtask

`ifdef I2S_TX_STEREO_EN
  task automatic test_stereo();
    bit sent;
    sent = 0;
    for (int i = 0; i < 1700; i++) begin
      tick(!sent, 32'h00123456, 32'h00FEDCBA);
      if (m_acc) sent = 1;
      n_cmp++;
      if (obs !== exp_vec) begin n_bad++; $display("FAIL stereo n=%0d got=%b exp=%b", m_n, obs, exp_vec); end
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 799) == 0) || ($urandom_range(0, 3) == 0 && m_full), $urandom, $urandom);
      n_cmp++;
      if (obs !== exp_vec) begin n_bad++; $display("FAIL random n=%0d got=%b exp=%b", m_n, obs, exp_vec); end
    end
  endtask

  initial begin
    apply_reset();
    test_reset();
    test_pattern();
    test_backpressure();
    test_underrun();
    test_bypass();
`ifdef I2S_TX_STEREO_EN
    test_stereo();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/i2s_dac_tx.md
# i2s_dac_tx

I2S transmitter that sits directly downstream of the 24-bit audio filter top. It accepts 32-bit DAC words (24-bit signed audio in bits [23:0], top 8 bits ignored) through a valid/ready handshake and buffers one sample. It generates BCLK and LRCLK from the system clock and shifts each sample out MSB-first in standard I2S format: 64 BCLK per frame, 32-bit slots, 24 data bits plus 8 zero pad bits.

## Interface
- BCLK_DIV, default 4: clk cycles per BCLK half-period. Must be ≥ 2. BCLK = clk/(2·BCLK_DIV).
- clk  in  1  system clock; every register is clocked on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- sample_in  in  32  DAC word. Bits [23:0] are the signed sample; bits [31:24] are ignored.
- sample_valid  in  1  sample_in is valid this cycle.
- sample_ready  out  1  holding register is empty; combinational, equal to ~full.
- sample_in_r  in  32  right-channel DAC word; present only when I2S_TX_STEREO_EN is defined.
- bclk  out  1  I2S bit clock (registered).
- lrclk  out  1  I2S word select: 0 = left, 1 = right (registered).
- sdata  out  1  I2S serial data; changes only on bclk falling edges (registered).
- sample_tick  out  1  one-cycle pulse on every frame load.
- underrun  out  1  one-cycle pulse on a frame load that found the holding register empty.

## Operation
- Divider counter div_cnt counts 0..BCLK_DIV-1. In the cycle where div_cnt = BCLK_DIV-1, bclk toggles. A 1→0 toggle is a "fall event".
- On each fall event, bit_cnt (6 bits) increments modulo 64. lrclk = 1 for bit_cnt 32..63 and 0 otherwise. lrclk, bit_cnt and sdata update in the same clk edge.
- Slot mapping:
  - bit_cnt k = 1..24 drives left[24-k].
  - k = 33..56 drives right[56-k].
  - All other slots drive 0. This includes slots 0 and 32, giving the I2S one-bit delay after each lrclk edge.
- Frame load happens on the fall event where bit_cnt wraps 63→0. In that cycle:
  - If the buffer is full: copy the holding register(s) into the frame register and clear full.
  - If the buffer is empty: keep the previous frame register contents (repeat the last sample) and pulse underrun.
  - sample_tick pulses on every load.
- Handshake: accept when sample_valid & sample_ready; this sets full.
- If an accept and a load occur in the same cycle with the buffer empty, the accepted sample bypasses straight into the frame register. In that case full stays 0 and no underrun pulse is generated.
- When full, sample_ready is 0 and sample_valid is ignored (no overwrite).
- Reset values (asynchronous):
  - div_cnt = 0, bit_cnt = 63, bclk = 0, lrclk = 1, sdata = 0.
  - full = 0, so sample_ready = 1.
  - Frame register = 0 (silence), sample_tick = 0, underrun = 0.
- Reset asserted mid-frame aborts the frame immediately. Nothing resumes; the post-reset sequence starts fresh.

## Timing
- Frame period: 128·BCLK_DIV clk cycles (512 at the default).
- After reset release, clk edges are numbered 1, 2, ….
  - First bclk rise: edge BCLK_DIV.
  - First fall event and first frame load: edge 2·BCLK_DIV. At this edge lrclk→0 and sample_tick pulses.
- Left MSB appears on sdata one BCLK period (2·BCLK_DIV cycles) after the load edge. Right MSB appears 33 BCLK periods after the load edge.
- sample_ready returns high in the cycle after a load that cleared full.
- Worst-case latency from accept to MSB on sdata: one frame period plus 2·BCLK_DIV cycles.

## Configuration
- I2S_TX_STEREO_EN defined:
  - The sample_in_r port exists.
  - The holding register and frame register each hold separate L and R samples, both captured on the same handshake.
  - The right slot carries sample_in_r[23:0].
- I2S_TX_STEREO_EN undefined:
  - No sample_in_r port and no right-channel storage.
  - The right slot repeats the left sample (mono duplicated onto both channels).

## Test plan
- Reset: drive reset low mid-frame → next cycle shows bclk = 0, lrclk = 1, sdata = 0, sample_ready = 1. After release: first bclk rise at edge 4; lrclk falls and sample_tick pulses at edge 8.
- Accept 0x00A5A5A5 before the first load → left slots 1..24 carry 1010_0101_1010_0101_1010_0101; slots 0 and 25..31 carry 0; right slot is identical (macro off). Then accept 0xFF800000 → MSB 1 followed by 23 zeros.
- Backpressure: offer two samples back-to-back → second is held until sample_ready rises one cycle after the next load; it is transmitted in the following frame, with no sample lost or overwritten.
- Underrun: no sample offered during a frame → underrun is a single-cycle pulse coincident with sample_tick, and sdata repeats the previous frame bit-for-bit.
- Bypass: with the buffer empty, assert sample_valid exactly at the load cycle with 0x00123456 → that sample appears in the same frame, underrun = 0, sample_ready remains 1.
- I2S_TX_STEREO_EN: L = 0x00123456, R = 0x00FEDCBA → left slot carries 0x123456 and right slot carries 0xFEDCBA, each MSB-first with the one-bit delay.
